// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing and a two-digit key history.
// Define KEYPAD_SYNC_EN to pass the row inputs through a 2-flop synchronizer.
module keypad_scanner #(
    parameter int SCAN_DIV   = 12000,
    parameter int DEB_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int MAXC = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESS,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_col, w_col_nxt;
    logic [1:0]      r_row, w_row_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_load;
    logic [3:0]      r_key_code, r_digit_new, r_digit_old;
    logic [3:0]      w_rows;
    logic            w_any_low;
    logic            w_row_low;
    logic [1:0]      w_low_row;

    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

`ifdef KEYPAD_SYNC_EN
    logic [3:0] r_rows_p0, r_rows_p1;

    // Row synchronizer stages; idle level is all rows released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rows_p0 <= 4'hF;
            r_rows_p1 <= 4'hF;
        end else begin
            r_rows_p0 <= rows;
            r_rows_p1 <= r_rows_p0;
        end
    end

    assign w_rows = r_rows_p1;
`else
    assign w_rows = rows;
`endif

    assign w_any_low = ~&w_rows;
    assign w_row_low = ~w_rows[r_row];

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        w_low_row = 2'd3;
        if (!w_rows[0])      w_low_row = 2'd0;
        else if (!w_rows[1]) w_low_row = 2'd1;
        else if (!w_rows[2]) w_low_row = 2'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_any_low) begin
                        w_row_nxt   = w_low_row;
                        w_state_nxt = S_DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!w_row_low) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                    w_state_nxt = S_PRESS;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PRESS: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!w_any_low) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_any_low) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_col_nxt   = r_col + 2'd1;
                    w_state_nxt = S_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    // Code is loaded on entry to PRESS so it is already valid during the key_valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_code  <= 4'h0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else if (w_load) begin
            r_key_code  <= map_key(r_row, r_col);
            r_digit_new <= map_key(r_row, r_col);
            r_digit_old <= r_digit_new;
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign key_valid = (r_state == S_PRESS);
    assign key_code  = r_key_code;
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls rows low for pressed keys
// whose column is driven, and hand-computed cycle counts are checked against the outputs.
module tb_keypad_scanner;

`ifdef KEYPAD_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [15:0] keys;   // bit r*4+c = key at row r, column c held down
    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    int base    = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) if (key_valid) n_pulse <= n_pulse + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step(1);
            if (key_valid) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, then first sample SCAN_DIV cycles after release; key '6' is r1/c2.
        reset = 1'b1;
        keys  = 16'h0;
        keys[6] = 1'b1;
        step(2);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_kv", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_new", digit_new, 0);
        chk("rst_old", digit_old, 0);
        base  = n_pulse;
        reset = 1'b0;
        step(3);
        chk("dwell_c0", cols, 4'b1110);
        step(1);
        chk("adv_c1", cols, 4'b1101);
        step(4);
        chk("drive_c2", cols, 4'b1011);
        // Sampled low at edge 12, PRESS after edge 20.
        step(11);
        chk("lat_pre", key_valid, 0);
        step(1);
        chk("lat_pulse", key_valid, 1);
        chk("k6_code", key_code, 4'h6);
        chk("k6_new", digit_new, 4'h6);
        chk("k6_old", digit_old, 4'h0);
        step(1);
        chk("pulse_1cyc", key_valid, 0);
        step(200);
        chk("hold_frozen", cols, 4'b1011);
        // Bouncy release, then steady high.
        keys[6] = 1'b0; step(2);
        keys[6] = 1'b1; step(2);
        keys[6] = 1'b0; step(2);
        keys[6] = 1'b1; step(2);
        keys[6] = 1'b0;
        step(8 + L);
        chk("rel_wait", cols, 4'b1011);
        step(1);
        chk("rel_scan_c3", cols, 4'b0111);
        chk("one_pulse", n_pulse - base, 1);

        // Press '5' (r1/c1), release, press 'A' (r0/c3).
        keys[5] = 1'b1;
        wait_pulse("p5_seen", 200);
        chk("k5_code", key_code, 4'h5);
        chk("k5_new", digit_new, 4'h5);
        chk("k5_old", digit_old, 4'h6);
        keys[5] = 1'b0;
        step(30);
        keys[3] = 1'b1;
        wait_pulse("pA_seen", 200);
        chk("kA_code", key_code, 4'hA);
        chk("kA_new", digit_new, 4'hA);
        chk("kA_old", digit_old, 4'h5);
        keys[3] = 1'b0;
        step(30);
        chk("three_pulses", n_pulse - base, 3);

        // Short low on row0 during DEBOUNCE: abort back to col0, no pulse.
        keys  = 16'h0;
        keys[0] = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        base  = n_pulse;
        step(7);
        keys[0] = 1'b0;
        step(4 + L);
        chk("glitch_same_col", cols, 4'b1110);
        step(1);
        chk("glitch_resume", cols, 4'b1101);
        step(40);
        chk("glitch_no_pulse", n_pulse - base, 0);

        // Rows 0 and 2 low together on col0: '1' wins over '7'.
        keys  = 16'h0;
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(11);
        chk("multi_pre", key_valid, 0);
        step(1);
        chk("multi_pulse", key_valid, 1);
        chk("multi_code", key_code, 4'h1);
        keys = 16'h0;
        step(30);

        // Reset during HOLD on col2 acts without a clock edge.
        keys[6] = 1'b1;
        wait_pulse("p6b_seen", 200);
        step(5);
        chk("hold_c2", cols, 4'b1011);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cols", cols, 4'b1110);
        chk("arst_kv", key_valid, 0);
        chk("arst_code", key_code, 0);
        chk("arst_new", digit_new, 0);
        chk("arst_old", digit_old, 0);
        keys = 16'h0;
        step(2);
        reset = 1'b0;
        base  = n_pulse;
        step(60);
        chk("arst_no_pulse", n_pulse - base, 0);
        keys[6] = 1'b1;
        wait_pulse("repress_seen", 200);
        chk("repress_code", key_code, 4'h6);
        chk("repress_old", digit_old, 4'h0);
        keys = 16'h0;
        step(20);
        chk("repress_one", n_pulse - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
